// File: rtl/riscv_regfile_sb.sv
// Integer register file with per-register busy scoreboard.
// Combinational reads bypass same-cycle writeback; flush drops all reservations.
module riscv_regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32,
    localparam int AW        = $clog2(REG_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         rs1_addr,
    input  logic [AW-1:0]         rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    output logic                  iss_ready,
    input  logic                  wb_valid,
    input  logic [AW-1:0]         wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  flush,
    output logic [AW:0]           busy_cnt
);

    logic [DATA_WIDTH-1:0] regs [REG_NUM];
    logic [REG_NUM-1:0]    busy;
    logic [REG_NUM-1:0]    busy_nxt;
    logic                  wb_we;
    logic                  iss_fire;
    logic                  wb_clr;
    logic                  cnt_inc;
    logic                  cnt_dec;
    logic [AW:0]           cnt_nxt;

    assign wb_we    = wb_valid && (wb_rd != '0);
    assign iss_fire = iss_valid && iss_ready && (iss_rd != '0);
    // A same-cycle reservation of the written register keeps it busy.
    assign wb_clr   = wb_we && !(iss_fire && (iss_rd == wb_rd));
    assign cnt_inc  = iss_fire && !busy[iss_rd];
    assign cnt_dec  = wb_clr && busy[wb_rd];

    always_comb begin
        iss_ready = 1'b1;
        if (!rst) begin
            iss_ready = !flush && ((iss_rd == '0) || !busy[iss_rd] ||
                                   (wb_valid && (wb_rd == iss_rd)));
        end
    end

    always_comb begin
        busy_nxt = busy;
        if (wb_clr)   busy_nxt[wb_rd]  = 1'b0;
        if (iss_fire) busy_nxt[iss_rd] = 1'b1;
        if (flush)    busy_nxt         = '0;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = busy_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
        if (flush) cnt_nxt = '0;
    end

    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if (!rst && (rs1_addr != '0)) begin
            if (wb_valid && (wb_rd == rs1_addr)) begin
                rs1_data = wb_data;
            end else begin
                rs1_data = regs[rs1_addr];
                rs1_busy = busy[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if (!rst && (rs2_addr != '0)) begin
            if (wb_valid && (wb_rd == rs2_addr)) begin
                rs2_data = wb_data;
            end else begin
                rs2_data = regs[rs2_addr];
                rs2_busy = busy[rs2_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wb_we) regs[wb_rd] <= wb_data;
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Self-checking bench for riscv_regfile_sb: directed vector table,
// random traffic against a scoreboard model, and async reset checks.
module tb_riscv_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic [5:0]  busy_cnt;

    int errors = 0;
    int checks = 0;

    riscv_regfile_sb dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        issv;
        logic [4:0]  issrd;
        logic        fl;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb1;
        logic        eb2;
        logic        erdy;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t tbl[16];

    // reference model state
    logic [31:0] mreg [32];
    bit          mbusy [32];

    function automatic vec_t mk(
        input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
        input logic issv, input logic [4:0] issrd, input logic fl,
        input logic [4:0] a1, input logic [4:0] a2,
        input logic [31:0] e1, input logic [31:0] e2,
        input logic eb1, input logic eb2, input logic erdy,
        input logic [5:0] ecnt);
        vec_t v;
        v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd;
        v.issv = issv; v.issrd = issrd; v.fl = fl;
        v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2;
        v.eb1 = eb1; v.eb2 = eb2; v.erdy = erdy; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic wbv, input logic [4:0] wbrd,
                         input logic [31:0] wbd, input logic issv,
                         input logic [4:0] issrd, input logic fl,
                         input logic [4:0] a1, input logic [4:0] a2);
        wb_valid = wbv; wb_rd = wbrd; wb_data = wbd;
        iss_valid = issv; iss_rd = issrd; flush = fl;
        rs1_addr = a1; rs2_addr = a2;
    endtask

    function automatic logic [31:0] m_data(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_valid && wb_rd == a) return wb_data;
        return mreg[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        return (a != 0) && mbusy[a] && !(wb_valid && wb_rd == a);
    endfunction

    function automatic logic m_ready();
        if (flush) return 1'b0;
        return (iss_rd == 0) || !mbusy[iss_rd] ||
               (wb_valid && wb_rd == iss_rd);
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            mreg[i] = 32'h0;
            mbusy[i] = 1'b0;
        end
    endtask

    initial begin
        tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0,
                     32'hDEADBEEF, 0, 0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 5, 5,
                     32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 0);
        tbl[2]  = mk(1, 0, 32'h1234, 1, 0, 0, 0, 5,
                     0, 32'hDEADBEEF, 0, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 1, 7, 0, 0, 7, 0, 0, 0, 0, 1, 1);
        tbl[4]  = mk(0, 0, 0, 1, 7, 0, 0, 7, 0, 0, 0, 1, 0, 1);
        tbl[5]  = mk(1, 7, 32'h55, 0, 7, 0, 7, 7,
                     32'h55, 32'h55, 0, 0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 1, 9, 0, 9, 0, 0, 0, 0, 0, 1, 1);
        tbl[7]  = mk(1, 9, 32'hAA, 1, 9, 0, 9, 7,
                     32'hAA, 32'h55, 0, 0, 1, 1);
        tbl[8]  = mk(0, 0, 0, 0, 9, 0, 9, 7,
                     32'hAA, 32'h55, 1, 0, 0, 1);
        tbl[9]  = mk(1, 9, 32'hAB, 0, 0, 0, 9, 7,
                     32'hAB, 32'h55, 0, 0, 1, 0);
        tbl[10] = mk(0, 0, 0, 1, 1, 0, 1, 2, 0, 0, 0, 0, 1, 1);
        tbl[11] = mk(0, 0, 0, 1, 2, 0, 1, 2, 0, 0, 1, 0, 1, 2);
        tbl[12] = mk(0, 0, 0, 1, 3, 0, 1, 2, 0, 0, 1, 1, 1, 3);
        tbl[13] = mk(1, 6, 32'h66, 1, 4, 1, 3, 4, 0, 0, 1, 0, 0, 0);
        tbl[14] = mk(1, 2, 32'h7, 0, 1, 0, 2, 4, 32'h7, 0, 0, 0, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 3, 0, 2, 6, 32'h7, 32'h66, 0, 0, 1, 0);

        // reset held: writeback and issue must be ignored
        rst = 1'b1;
        drive(1, 5, 32'hCAFE, 1, 5, 0, 5, 5);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rs1_data", rs1_data, 0);
        chk("rst_rs2_busy", {31'b0, rs2_busy}, 0);
        chk("rst_iss_ready", {31'b0, iss_ready}, 1);
        chk("rst_busy_cnt", {26'b0, busy_cnt}, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            drive(tbl[i].wbv, tbl[i].wbrd, tbl[i].wbd, tbl[i].issv,
                  tbl[i].issrd, tbl[i].fl, tbl[i].a1, tbl[i].a2);
            #1;
            chk($sformatf("v%0d_rs1_data", i), rs1_data, tbl[i].e1);
            chk($sformatf("v%0d_rs2_data", i), rs2_data, tbl[i].e2);
            chk($sformatf("v%0d_rs1_busy", i), {31'b0, rs1_busy},
                {31'b0, tbl[i].eb1});
            chk($sformatf("v%0d_rs2_busy", i), {31'b0, rs2_busy},
                {31'b0, tbl[i].eb2});
            chk($sformatf("v%0d_iss_ready", i), {31'b0, iss_ready},
                {31'b0, tbl[i].erdy});
            @(posedge clk);
            #1;
            drive(0, 0, 0, 0, 0, 0, tbl[i].a1, tbl[i].a2);
            chk($sformatf("v%0d_busy_cnt", i), {26'b0, busy_cnt},
                {26'b0, tbl[i].ecnt});
        end

        // async reset between edges with a reservation pending
        @(posedge clk);
        #1;
        drive(0, 0, 0, 1, 3, 0, 5, 3);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 5, 3);
        #1;
        chk("pre_rst_rs2_busy", {31'b0, rs2_busy}, 1);
        chk("pre_rst_rs1_data", rs1_data, 32'hDEADBEEF);
        #1;
        drive(1, 4, 32'hFFFF, 1, 3, 0, 5, 3);
        rst = 1'b1;
        #1;
        chk("arst_rs1_data", rs1_data, 0);
        chk("arst_rs2_busy", {31'b0, rs2_busy}, 0);
        chk("arst_busy_cnt", {26'b0, busy_cnt}, 0);
        chk("arst_iss_ready", {31'b0, iss_ready}, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 5, 6);
        #1;
        chk("post_rst_rs1_data", rs1_data, 0);
        chk("post_rst_rs2_data", rs2_data, 0);
        m_reset();

        // random traffic against the scoreboard model
        for (int n = 0; n < 600; n++) begin
            logic fire;
            @(posedge clk);
            #1;
            drive($urandom_range(0, 1), 5'($urandom_range(0, 9)), $urandom,
                  $urandom_range(0, 1), 5'($urandom_range(0, 9)),
                  ($urandom_range(0, 24) == 0),
                  5'($urandom_range(0, 9)), 5'($urandom_range(0, 31)));
            if (wb_valid && iss_valid && wb_rd == iss_rd && !mbusy[iss_rd])
                iss_valid = 1'b0;
            #1;
            chk("rnd_rs1_data", rs1_data, m_data(rs1_addr));
            chk("rnd_rs2_data", rs2_data, m_data(rs2_addr));
            chk("rnd_rs1_busy", {31'b0, rs1_busy}, {31'b0, m_busy(rs1_addr)});
            chk("rnd_rs2_busy", {31'b0, rs2_busy}, {31'b0, m_busy(rs2_addr)});
            chk("rnd_iss_ready", {31'b0, iss_ready}, {31'b0, m_ready()});
            fire = iss_valid && m_ready() && iss_rd != 0;
            if (wb_valid && wb_rd != 0) begin
                mreg[wb_rd] = wb_data;
                if (!(fire && iss_rd == wb_rd)) mbusy[wb_rd] = 1'b0;
            end
            if (fire) mbusy[iss_rd] = 1'b1;
            if (flush) for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
            @(posedge clk);
            #1;
            chk("rnd_busy_cnt", {26'b0, busy_cnt}, 32'(m_count()));
            drive(0, 0, 0, 0, 0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_regfile_sb.md
RISCV_REGFILE_SB -- requirements
Module: riscv_regfile_sb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, width of each architectural register and of all data ports.
REQ-002 SHALL have parameter REG_NUM, 32, number of architectural registers; address width AW = log2(REG_NUM) = 5.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports rs1_addr / rs2_addr  input  AW  IDU source register read addresses.
REQ-006 SHALL have ports rs1_data / rs2_data  output  DATA_WIDTH  combinational read data, with bypass.
REQ-007 SHALL have ports rs1_busy / rs2_busy  output  1  source register has a pending writeback.
REQ-008 SHALL have ports iss_valid  input  1, iss_rd  input  AW  reservation of a destination register by an issuing instruction.
REQ-009 SHALL have port iss_ready  output  1  reservation accepted this cycle.
REQ-010 SHALL have ports wb_valid  input  1, wb_rd  input  AW, wb_data  input  DATA_WIDTH  result from WBU.
REQ-011 SHALL have port flush  input  1  clears all reservations (redirect/trap).
REQ-012 SHALL have port busy_cnt  output  AW+1  number of currently reserved registers.

Function
REQ-013 SHALL hold REG_NUM x DATA_WIDTH storage plus one busy bit per register; x0 storage and busy bit are constant 0.
REQ-014 SHALL write wb_data to reg[wb_rd] at the clock edge when wb_valid and wb_rd != 0; writes to x0 are discarded.
REQ-015 SHALL drive rsN_data = 0 when rsN_addr == 0; else wb_data when wb_valid && wb_rd == rsN_addr; else reg[rsN_addr].
REQ-016 SHALL drive rsN_busy = busy[rsN_addr] && !(wb_valid && wb_rd == rsN_addr); always 0 for address 0.
REQ-017 SHALL drive iss_ready = (iss_rd == 0) || !busy[iss_rd] || (wb_valid && wb_rd == iss_rd), and 0 while flush is high.
REQ-018 SHALL complete a reservation when iss_valid && iss_ready && iss_rd != 0: busy[iss_rd] set at the edge; iss_rd == 0 is accepted with no state change.
REQ-019 SHALL clear busy[wb_rd] at the edge on wb_valid, unless the same register is reserved in the same cycle; then busy stays 1 (issue wins, data still written).
REQ-020 SHALL clear all busy bits at the edge when flush is high, overriding any same-cycle reservation; a same-cycle writeback still updates data.
REQ-021 SHALL accept a writeback to a register whose busy bit is 0: data written, busy stays 0, no error.
REQ-022 SHALL maintain busy_cnt as a registered count: +1 per completed reservation of a non-busy register, -1 per busy bit cleared by writeback, net 0 when both hit the same register; set to 0 on flush; never wraps (max REG_NUM-1).
REQ-023 SHALL have zero-cycle read latency and one-cycle write-to-storage latency; bypass makes written data visible in the same cycle.

Reset
REQ-024 SHALL, while rst is high (asynchronously, including mid-operation), clear all registers to 0, all busy bits to 0, busy_cnt to 0.
REQ-025 SHALL hold outputs at reset values for rsN_data = 0, rsN_busy = 0, iss_ready = 1 while rst is high, ignoring iss_valid/wb_valid.

Verification
REQ-026 SHALL verify write/read: wb x5 = 0xDEADBEEF; same cycle rs1_addr=5 -> rs1_data=0xDEADBEEF; next cycle no wb -> still 0xDEADBEEF.
REQ-027 SHALL verify x0: wb x0 = 0x1234, iss_rd=0 -> rs1_data(0)=0, busy_cnt=0, iss_ready=1.
REQ-028 SHALL verify hazard: reserve x7 -> rs2_busy(7)=1, busy_cnt=1, second iss_rd=7 -> iss_ready=0; wb x7=0x55 -> same-cycle rs2_busy=0, rs2_data=0x55, next busy_cnt=0.
REQ-029 SHALL verify simultaneous: x9 busy, same cycle wb x9=0xAA and iss x9 -> iss_ready=1, next cycle busy[9]=1, reg[9]=0xAA, busy_cnt unchanged (1).
REQ-030 SHALL verify flush: reserve x1,x2,x3 (busy_cnt=3), flush with iss x4 -> next cycle all busy 0, busy_cnt=0; later wb x2=0x7 -> reg[2]=0x7, busy_cnt=0.
REQ-031 SHALL verify async reset: after writes/reservations, assert rst between edges -> immediately all rsN_data=0, busy=0, busy_cnt=0.
